nvm_flash_ctrl: RTL and testbench

Parametrised flash-style non-volatile memory with an internal operation sequencer. It is the successor to the plain single-port memory model. It adds a valid/ready request handshake, a registered read port, byte-enabled bit-clearing program operations, multi-cycle page erase, page write-protection and busy/error signalling. It sits behind the instruction/data bus bridge as the program-storage array of the microcontroller.

---
 rtl/nvm_flash_ctrl.sv | 157 +++++++++++++++
 tb/tb_nvm_flash_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_flash_ctrl.sv
// Flash-style NVM array with a request sequencer: registered reads, bit-clearing
// byte-enabled programs, multi-cycle page erase, page write-protection.
module nvm_flash_ctrl #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned MEM_DATA_WIDTH = 32,
  parameter int unsigned PAGE_WORDS     = 16,
  parameter int unsigned PROG_CYCLES    = 8,
  parameter int unsigned ERASE_CYCLES   = 32,
  parameter int unsigned LOCK_PAGES     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [MEM_ADDR_WIDTH-1:0]   addr,
  input  logic [MEM_DATA_WIDTH-1:0]   wdata,
  input  logic [MEM_DATA_WIDTH/8-1:0] be,
  input  logic                        unlock,
  output logic [MEM_DATA_WIDTH-1:0]   rdata,
  output logic                        rvalid,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned BE_W       = MEM_DATA_WIDTH / 8;
  localparam int unsigned DEPTH      = 2 ** MEM_ADDR_WIDTH;
  localparam int unsigned PAGE_BITS  = $clog2(PAGE_WORDS);
  localparam int unsigned PAGE_IDX_W = MEM_ADDR_WIDTH - PAGE_BITS;
  localparam int unsigned CNT_W      = $clog2(ERASE_CYCLES + 1);
  localparam int unsigned WCNT_W     = PAGE_BITS + 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  typedef enum logic [1:0] {IDLE, PROG, ERASE} state_t;

  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [WCNT_W-1:0]         wcnt;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]           be_q;

  logic                      req_locked_c;
  logic [MEM_DATA_WIDTH-1:0] prog_word_c;
  logic                      mem_we_c;
  logic [MEM_ADDR_WIDTH-1:0] mem_waddr_c;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata_c;

  // Protected page check against the live request inputs at acceptance.
  always_comb begin
    req_locked_c = (addr[MEM_ADDR_WIDTH-1:PAGE_BITS] < PAGE_IDX_W'(LOCK_PAGES)) && !unlock;
  end

  // Program can only clear bits within enabled bytes.
  always_comb begin
    prog_word_c = mem[addr_q];
    for (int b = 0; b < BE_W; b++) begin
      if (be_q[b]) begin
        prog_word_c[8*b +: 8] = mem[addr_q][8*b +: 8] & wdata_q[8*b +: 8];
      end
    end
  end

  // Single array write port: last PROG cycle, or first PAGE_WORDS ERASE cycles.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = addr_q;
    mem_wdata_c = prog_word_c;
    if (state == PROG && cnt == '0) begin
      mem_we_c = 1'b1;
    end else if (state == ERASE && !wcnt[WCNT_W-1]) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = {addr_q[MEM_ADDR_WIDTH-1:PAGE_BITS], wcnt[PAGE_BITS-1:0]};
      mem_wdata_c = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      cnt       <= '0;
      wcnt      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            case (req_op)
              OP_READ: begin
                rdata  <= mem[addr];
                rvalid <= 1'b1;
              end
              OP_PROG, OP_ERASE: begin
                if (req_locked_c) begin
                  err <= 1'b1;
                end else begin
                  addr_q    <= addr;
                  wdata_q   <= wdata;
                  be_q      <= be;
                  wcnt      <= '0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  if (req_op == OP_PROG) begin
                    state <= PROG;
                    cnt   <= CNT_W'(PROG_CYCLES - 1);
                  end else begin
                    state <= ERASE;
                    cnt   <= CNT_W'(ERASE_CYCLES - 1);
                  end
                end
              end
              default: err <= 1'b1;
            endcase
          end
        end
        PROG, ERASE: begin
          if (!wcnt[WCNT_W-1]) begin
            wcnt <= wcnt + WCNT_W'(1);
          end
          if (cnt == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_flash_ctrl.sv
// Scoreboard bench for nvm_flash_ctrl: read results queued at issue, checked on rvalid.
module tb_nvm_flash_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned N_PROG  = 8;
  localparam int unsigned N_ERASE = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [BW-1:0] be = '0;
  logic          unlock = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid, busy, done, err;

  always #5 clk = ~clk;

  nvm_flash_ctrl #(
    .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .PAGE_WORDS(16),
    .PROG_CYCLES(N_PROG), .ERASE_CYCLES(N_ERASE), .LOCK_PAGES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .addr(addr), .wdata(wdata), .be(be), .unlock(unlock),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_rv = 0;
  int prev_rv = 0;
  logic [DW-1:0] model [1024];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pulse exclusivity, event counts and read scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || err || rvalid)
        check("excl", 32'(done) + 32'(err) + 32'(rvalid), 32'd1);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (rvalid) begin
        prev_rv = last_rv;
        last_rv = cyc;
        if (exp_q.size() == 0) check("rv_unexp", 32'd1, 32'd0);
        else check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int a, input logic [DW-1:0] d,
                       input logic [BW-1:0] b, input logic ul);
    int n;
    n = 0;
    req_op = op; addr = AW'(a); wdata = d; be = b; unlock = ul; req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    issue(2'b00, a, '0, '0, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic prog(input int a, input logic [DW-1:0] d, input logic [BW-1:0] b, input logic ul);
    int n;
    issue(2'b01, a, d, b, ul);
    wait_idle(n);
    check("prog_busy_cycles", 32'(n), 32'(N_PROG));
    check("prog_done", 32'(done), 32'd1);
    check("prog_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < BW; i++)
      if (b[i]) model[a][8*i +: 8] = model[a][8*i +: 8] & d[8*i +: 8];
  endtask

  task automatic erase(input int a);
    int n;
    issue(2'b10, a, '0, '0, 1'b0);
    wait_idle(n);
    check("erase_busy_cycles", 32'(n), 32'(N_ERASE));
    check("erase_done", 32'(done), 32'd1);
    for (int i = 0; i < 16; i++) model[(a & ~15) + i] = '1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    for (int i = 0; i < 1024; i++) begin
      dut.mem[i] = '1;
      model[i] = '1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);

    // Reads after reset, back to back
    rd(32'h005, 32'hFFFF_FFFF);
    rd(32'h006, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    check("b2b_rvalid_gap", 32'(last_rv - prev_rv), 32'd1);

    // Byte-enabled bit-clearing program
    prog(32'h020, 32'h1234_5678, 4'b0101, 1'b0);
    rd(32'h020, 32'hFF34_FF78);
    prog(32'h020, 32'h00FF_00FF, 4'hF, 1'b0);
    rd(32'h020, 32'h0034_0078);

    // Protected page: rejected, then accepted with unlock
    e0 = err_cnt;
    issue(2'b01, 32'h003, 32'h0, 4'hF, 1'b0);
    check("lock_err", 32'(err), 32'd1);
    check("lock_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("lock_err_pulse", 32'(err), 32'd0);
    check("lock_busy2", 32'(busy), 32'd0);
    rd(32'h003, 32'hFFFF_FFFF);
    prog(32'h003, 32'h0F0F_0F0F, 4'hF, 1'b1);
    rd(32'h003, 32'h0F0F_0F0F);
    issue(2'b10, 32'h007, 32'h0, 4'h0, 1'b0);
    check("lock_erase_err", 32'(err), 32'd1);
    @(posedge clk); #1;
    check("lock_err_count", 32'(err_cnt - e0), 32'd2);
    rd(32'h003, 32'h0F0F_0F0F);

    // Page erase with neighbours untouched
    prog(32'h01F, 32'hA5A5_A5A5, 4'hF, 1'b0);
    prog(32'h030, 32'h5A5A_5A5A, 4'hF, 1'b0);
    for (int i = 32'h020; i <= 32'h02F; i++) prog(i, 32'h0, 4'hF, 1'b0);
    rd(32'h02A, 32'h0);
    erase(32'h025);
    for (int i = 32'h020; i <= 32'h02F; i++) rd(i, 32'hFFFF_FFFF);
    rd(32'h01F, 32'hA5A5_A5A5);
    rd(32'h030, 32'h5A5A_5A5A);

    // Reset in the middle of an erase
    for (int i = 32'h040; i <= 32'h04F; i++) prog(i, DW'(32'h4000_0000 + i * 32'h0101), 4'hF, 1'b0);
    issue(2'b10, 32'h040, 32'h0, 4'h0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 32'h040; i <= 32'h043; i++) model[i] = '1;
    for (int i = 32'h040; i <= 32'h04F; i++) rd(i, model[i]);

    // Reserved op
    issue(2'b11, 32'h100, 32'h0, 4'hF, 1'b1);
    check("rsv_err", 32'(err), 32'd1);
    check("rsv_busy", 32'(busy), 32'd0);
    check("rsv_done", 32'(done), 32'd0);
    check("rsv_rvalid", 32'(rvalid), 32'd0);
    check("rsv_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rsv_err_pulse", 32'(err), 32'd0);

    // Request held during busy is accepted once afterwards
    d0 = done_cnt;
    issue(2'b01, 32'h050, 32'h0, 4'hF, 1'b0);
    model[32'h050] = '0;
    prog(32'h051, 32'h1234_0000, 4'hF, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check("held_done_count", 32'(done_cnt - d0), 32'd2);
    check("held_idle_busy", 32'(busy), 32'd0);
    rd(32'h050, 32'h0);
    rd(32'h051, 32'h1234_0000);

    // Last page and all-ones address
    prog(32'h3EF, 32'h3CC3_3CC3, 4'hF, 1'b0);
    prog(32'h3FF, 32'h0000_1111, 4'b0011, 1'b0);
    rd(32'h3FF, 32'hFFFF_1111);
    erase(32'h3FA);
    rd(32'h3FF, 32'hFFFF_FFFF);
    rd(32'h3F0, 32'hFFFF_FFFF);
    rd(32'h3EF, 32'h3CC3_3CC3);
    rd(32'h000, 32'hFFFF_FFFF);

    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
